// File: rtl/rojo_frame_sync_ctrl_pkg.sv
// Shared types and register map for the Rojobot frame-synchronised sprite controller.
package rojo_pkg;

  typedef struct packed {
    logic [2:0] orient;
    logic [7:0] y;
    logic [7:0] x;
  } bot_pos_t;

  localparam logic [1:0] REG_SHADOW = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_ACTIVE = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    COMMIT = 2'd2
  } fsync_state_t;

  function automatic logic [31:0] pos_word(input bot_pos_t p);
    return {13'd0, p};
  endfunction

  // Byte-lane merge of a bus write into a sprite position.
  function automatic bot_pos_t pos_merge(input bot_pos_t cur, input logic [18:0] d,
                                         input logic [2:0] sel);
    bot_pos_t r;
    r = cur;
    if (sel[0]) r.x = d[7:0];
    if (sel[1]) r.y = d[15:8];
    if (sel[2]) r.orient = d[18:16];
    return r;
  endfunction

endpackage

// File: rtl/rojo_frame_sync_ctrl_if.sv
// Wishbone classic bus bundle between the CPU and the frame-sync controller.
interface rojo_frame_sync_ctrl_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/rojo_frame_sync_ctrl_vblank_detect.sv
// Detects the first cycle of vertical blank and counts frames.
module rojo_vblank_detect #(
  parameter int V_VISIBLE = 768,
  parameter int ROW_W     = 12
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [ROW_W-1:0] pixel_row,
  output logic             tick,
  output logic             frame_tick_o,
  output logic [15:0]      frame_cnt
);

  localparam logic [ROW_W-1:0] VB_ROW = ROW_W'(V_VISIBLE);

  logic [ROW_W-1:0] row_q;

  // Edge on entry to the blanking row, not a level while the row is held.
  assign tick = (pixel_row == VB_ROW) && (row_q != VB_ROW);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      row_q        <= '0;
      frame_tick_o <= 1'b0;
      frame_cnt    <= 16'd0;
    end else begin
      row_q        <= pixel_row;
      frame_tick_o <= tick;
      if (tick) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/rojo_frame_sync_ctrl.sv
// Wishbone register file plus commit FSM that copies shadow sprite position
// to the display-facing registers only at the start of vertical blank.
module rojo_frame_sync_ctrl
  import rojo_pkg::*;
#(
  parameter int V_VISIBLE = 768,
  parameter int ROW_W     = 12,
  parameter int RESET_X   = 0,
  parameter int RESET_Y   = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  rojo_frame_sync_ctrl_if.slave wb,
  input  logic [ROW_W-1:0]      pixel_row,
  input  logic [ROW_W-1:0]      pixel_column,
  output logic [7:0]            active_x,
  output logic [7:0]            active_y,
  output logic [2:0]            active_orient,
  output logic                  frame_tick_o,
  output logic                  irq_o
);

  localparam bot_pos_t POS_RST = '{orient: 3'd0, y: 8'(RESET_Y), x: 8'(RESET_X)};

  fsync_state_t state;
  bot_pos_t     shadow, active, shadow_nxt;
  logic         irq_en, irq_st, irq_en_nxt, irq_st_nxt;
  logic         tick, pending;
  logic [15:0]  frame_cnt;
  logic         req, wr, arm_wr, irq_clr;
  logic [1:0]   adr;
  logic [31:0]  rdata;
  logic         unused_bits;

  rojo_vblank_detect #(.V_VISIBLE(V_VISIBLE), .ROW_W(ROW_W)) u_vblank (
    .clk          (clk),
    .rstn         (rstn),
    .pixel_row    (pixel_row),
    .tick         (tick),
    .frame_tick_o (frame_tick_o),
    .frame_cnt    (frame_cnt)
  );

  assign unused_bits = ^{pixel_column, wb.wb_adr_i[31:4], wb.wb_adr_i[1:0],
                         wb.wb_dat_i[31:19], wb.wb_sel_i[3]};

  // A new access is accepted only while ack is low, giving one access per two clocks.
  assign req     = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o;
  assign wr      = req & wb.wb_we_i;
  assign adr     = wb.wb_adr_i[3:2];
  assign arm_wr  = wr && (adr == REG_CTRL) && wb.wb_sel_i[0] && wb.wb_dat_i[0];
  assign irq_clr = wr && (adr == REG_STATUS) && wb.wb_sel_i[0] && wb.wb_dat_i[1];
  assign pending = (state != IDLE);

  assign shadow_nxt = (wr && adr == REG_SHADOW)
                    ? pos_merge(shadow, wb.wb_dat_i[18:0], wb.wb_sel_i[2:0]) : shadow;
  assign irq_en_nxt = (wr && adr == REG_CTRL && wb.wb_sel_i[0]) ? wb.wb_dat_i[1] : irq_en;
  // Commit sets IRQ with priority over a coincident W1C.
  assign irq_st_nxt = (state == COMMIT) ? 1'b1 : (irq_clr ? 1'b0 : irq_st);

  always_comb begin
    rdata = 32'd0;
    case (adr)
      REG_SHADOW: rdata = pos_word(shadow);
      REG_CTRL:   rdata = {30'd0, irq_en, 1'b0};
      REG_STATUS: rdata = {frame_cnt, 14'd0, irq_st, pending};
      REG_ACTIVE: rdata = pos_word(active);
      default:    rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wb.wb_ack_o <= 1'b0;
      wb.wb_dat_o <= 32'd0;
      shadow      <= POS_RST;
      irq_en      <= 1'b0;
      irq_st      <= 1'b0;
      irq_o       <= 1'b0;
    end else begin
      wb.wb_ack_o <= req;
      wb.wb_dat_o <= req ? rdata : 32'd0;
      shadow      <= shadow_nxt;
      irq_en      <= irq_en_nxt;
      irq_st      <= irq_st_nxt;
      irq_o       <= irq_st_nxt & irq_en_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      active <= POS_RST;
    end else begin
      case (state)
        IDLE:    if (arm_wr) state <= ARMED;
        ARMED:   if (tick) state <= COMMIT;
        COMMIT: begin
          // Shadow as updated this cycle, so a same-cycle write is included.
          active <= shadow_nxt;
          state  <= arm_wr ? ARMED : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign active_x      = active.x;
  assign active_y      = active.y;
  assign active_orient = active.orient;

endmodule

// File: tb/tb_rojo_frame_sync_ctrl.sv
// Directed bench for the frame-sync sprite controller.
module tb_rojo_frame_sync_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [11:0] pixel_row, pixel_column;
  logic [7:0]  active_x, active_y;
  logic [2:0]  active_orient;
  logic        frame_tick_o, irq_o;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_fc = 16'd0;

  rojo_frame_sync_ctrl_if bus ();

  rojo_frame_sync_ctrl dut (
    .clk           (clk),
    .rstn          (rstn),
    .wb            (bus),
    .pixel_row     (pixel_row),
    .pixel_column  (pixel_column),
    .active_x      (active_x),
    .active_y      (active_y),
    .active_orient (active_orient),
    .frame_tick_o  (frame_tick_o),
    .irq_o         (irq_o)
  );

  always #5 clk = ~clk;

  task automatic bus_idle();
    bus.wb_adr_i = 32'd0; bus.wb_dat_i = 32'd0; bus.wb_sel_i = 4'd0;
    bus.wb_we_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
  endtask

  task automatic bus_start(input logic [1:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic we);
    bus.wb_adr_i = {28'd0, a, 2'b00}; bus.wb_dat_i = d; bus.wb_sel_i = s;
    bus.wb_we_i = we; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    bus_start(a, d, s, 1'b1);
    @(posedge clk); #1;
    bus_idle();
    @(posedge clk); #1;
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] d,
                         output logic ack1, output logic ack2);
    bus_start(a, 32'd0, 4'hF, 1'b0);
    @(posedge clk); #1;
    d = bus.wb_dat_o; ack1 = bus.wb_ack_o;
    bus_idle();
    @(posedge clk); #1;
    ack2 = bus.wb_ack_o;
  endtask

  task automatic row_to(input logic [11:0] r);
    pixel_row = r;
    @(posedge clk); #1;
  endtask

  task automatic frame();
    row_to(12'd767); row_to(12'd768); row_to(12'd768); row_to(12'd0);
    exp_fc = exp_fc + 16'd1;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic a1, a2;
    rstn = 1'b0; bus_idle(); pixel_row = 12'd0; pixel_column = 12'd0;
    repeat (2) @(posedge clk); #1;
    rstn = 1'b1;
    exp_fc = 16'd0;
    n_checks++; if (bus.wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", bus.wb_ack_o); end
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq_o); end
    wb_read(2'd3, d, a1, a2);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_active: got %h want 00000000", d); end
    n_checks++; if (a1 !== 1'b1 || a2 !== 1'b0) begin n_fail++; $display("FAIL ack_pulse: got %b%b want 10", a1, a2); end
    wb_read(2'd2, d, a1, a2);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_status: got %h want 00000000", d); end
  endtask

  task automatic test_commit();
    logic [31:0] d; logic a1, a2;
    wb_write(2'd0, 32'h0003_2A15, 4'hF);
    wb_write(2'd1, 32'h0000_0001, 4'hF);
    row_to(12'd767);
    row_to(12'd768);
    n_checks++; if (active_x !== 8'h00) begin n_fail++; $display("FAIL commit_early: got %h want 00", active_x); end
    n_checks++; if (frame_tick_o !== 1'b1) begin n_fail++; $display("FAIL frame_tick: got %b want 1", frame_tick_o); end
    row_to(12'd768);
    n_checks++; if ({active_orient, active_y, active_x} !== {3'd3, 8'h2A, 8'h15}) begin
      n_fail++; $display("FAIL commit_pos: got %h/%h/%h want 3/2a/15", active_orient, active_y, active_x); end
    n_checks++; if (frame_tick_o !== 1'b0) begin n_fail++; $display("FAIL frame_tick_pulse: got %b want 0", frame_tick_o); end
    row_to(12'd0);
    exp_fc = exp_fc + 16'd1;
    wb_read(2'd2, d, a1, a2);
    n_checks++; if (d !== 32'h0001_0002) begin n_fail++; $display("FAIL commit_status: got %h want 00010002", d); end
    wb_read(2'd3, d, a1, a2);
    n_checks++; if (d !== 32'h0003_2A15) begin n_fail++; $display("FAIL commit_active_rd: got %h want 00032a15", d); end
  endtask

  task automatic test_no_arm();
    logic [31:0] d; logic a1, a2;
    wb_write(2'd0, 32'h0005_4433, 4'hF);
    for (int i = 0; i < 3; i++) begin
      frame();
      wb_read(2'd2, d, a1, a2);
      n_checks++; if (d[31:16] !== exp_fc) begin n_fail++; $display("FAIL frame_cnt_%0d: got %h want %h", i, d[31:16], exp_fc); end
    end
    wb_read(2'd3, d, a1, a2);
    n_checks++; if (d !== 32'h0003_2A15) begin n_fail++; $display("FAIL no_arm_active: got %h want 00032a15", d); end
  endtask

  task automatic test_arm_on_tick();
    logic [31:0] d; logic a1, a2;
    row_to(12'd767);
    bus_start(2'd1, 32'h0000_0001, 4'hF, 1'b1);
    pixel_row = 12'd768;
    @(posedge clk); #1;
    bus_idle();
    @(posedge clk); #1;
    exp_fc = exp_fc + 16'd1;
    n_checks++; if (active_x !== 8'h15) begin n_fail++; $display("FAIL arm_tick_nocommit: got %h want 15", active_x); end
    wb_read(2'd2, d, a1, a2);
    n_checks++; if (d !== {exp_fc, 16'h0003}) begin n_fail++; $display("FAIL arm_tick_pending: got %h want %h", d, {exp_fc, 16'h0003}); end
    row_to(12'd0);
    frame();
    n_checks++; if ({active_orient, active_y, active_x} !== {3'd5, 8'h44, 8'h33}) begin
      n_fail++; $display("FAIL arm_tick_late: got %h/%h/%h want 5/44/33", active_orient, active_y, active_x); end
    wb_read(2'd2, d, a1, a2);
    n_checks++; if (d[0] !== 1'b0) begin n_fail++; $display("FAIL arm_tick_idle: got %b want 0", d[0]); end
  endtask

  task automatic test_irq();
    logic [31:0] d; logic a1, a2;
    wb_write(2'd2, 32'h0000_0002, 4'hF);
    wb_write(2'd1, 32'h0000_0002, 4'hF);
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_cleared: got %b want 0", irq_o); end
    wb_write(2'd1, 32'h0000_0003, 4'hF);
    frame();
    n_checks++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %b want 1", irq_o); end
    wb_write(2'd2, 32'h0000_0002, 4'hF);
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_w1c: got %b want 0", irq_o); end
    wb_write(2'd1, 32'h0000_0003, 4'hF);
    row_to(12'd767);
    row_to(12'd768);
    wb_write(2'd2, 32'h0000_0002, 4'hF);
    exp_fc = exp_fc + 16'd1;
    row_to(12'd0);
    n_checks++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_set_wins: got %b want 1", irq_o); end
    wb_read(2'd2, d, a1, a2);
    n_checks++; if (d !== {exp_fc, 16'h0002}) begin n_fail++; $display("FAIL irq_status: got %h want %h", d, {exp_fc, 16'h0002}); end
  endtask

  task automatic test_byte_write();
    logic [31:0] d; logic a1, a2;
    wb_write(2'd0, 32'h0001_1122, 4'hF);
    wb_write(2'd0, 32'h0000_7700, 4'b0010);
    wb_read(2'd0, d, a1, a2);
    n_checks++; if (d !== 32'h0001_7722) begin n_fail++; $display("FAIL byte_lane: got %h want 00017722", d); end
  endtask

  task automatic test_reset_armed();
    logic [31:0] d; logic a1, a2;
    wb_write(2'd1, 32'h0000_0001, 4'hF);
    wb_read(2'd2, d, a1, a2);
    n_checks++; if (d[0] !== 1'b1) begin n_fail++; $display("FAIL armed_pending: got %b want 1", d[0]); end
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    exp_fc = 16'd0;
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b want 0", irq_o); end
    wb_write(2'd0, 32'h0002_5566, 4'hF);
    frame();
    wb_read(2'd3, d, a1, a2);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL rst_armed_nocommit: got %h want 00000000", d); end
    wb_read(2'd2, d, a1, a2);
    n_checks++; if (d !== 32'h0001_0000) begin n_fail++; $display("FAIL rst_armed_status: got %h want 00010000", d); end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_no_arm();
    test_arm_on_tick();
    test_irq();
    test_byte_write();
    test_reset_armed();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
